// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller for a 2-stage pipelined 32x32 unsigned multiplier.
// Drives sign-magnitude operands, tracks latency, writes HI/LO, raises stall while busy.
// Ports: clk, rst (sync, active-low); start/is_signed/op_a/op_b request a multiply;
// rd_req/mthi/mtlo/wdata are HI/LO accesses; mul_a/mul_b/mul_y connect the multiplier;
// hi/lo registers; busy/done/stall status. Option: MUL_CTRL_MADD_EN adds acc (MADD/MADDU).
module mul_ctrl #(
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        rd_req,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_y,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
`ifdef MUL_CTRL_MADD_EN
  input  logic        acc,
`endif
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB
  } state_t;

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MUL_LAT);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;
  logic             accept;
  logic             capture;
  logic             wr_en;
  logic [63:0]      prod;
  logic [63:0]      hilo_nx;

  assign mul_a = (is_signed & op_a[31]) ? (32'd0 - op_a) : op_a;
  assign mul_b = (is_signed & op_b[31]) ? (32'd0 - op_b) : op_b;

  assign busy  = (state_q == RUN);
  assign done  = (state_q == WB);
  assign stall = busy & (start | rd_req | mthi | mtlo);

  // stall only exists while busy, so a non-busy cycle takes both
  assign accept = start & ~busy;
  assign wr_en  = ~busy;

  assign prod = neg_q ? (64'd0 - mul_y) : mul_y;

`ifdef MUL_CTRL_MADD_EN
  logic acc_q;
  assign hilo_nx = acc_q ? ({hi, lo} + prod) : prod;
`else
  assign hilo_nx = prod;
`endif

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) state_d = RUN;
      end
      (state_q == RUN): begin
        if (cnt_q == LAT_C) begin
          capture = 1'b1;
          state_d = WB;
        end
      end
      (state_q == WB): begin
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MUL_CTRL_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_W'(1);
        neg_q <= is_signed & (op_a[31] ^ op_b[31]);
`ifdef MUL_CTRL_MADD_EN
        acc_q <= acc;
`endif
      end else if (busy) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (capture) begin
        {hi, lo} <= hilo_nx;
      end else if (wr_en) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed bench for mul_ctrl with a transaction-level HI/LO model.
// A 2-stage multiplier model feeds mul_y; outputs are compared every negedge.
module tb_mul_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 0;
  logic        rst, start, is_signed, rd_req, mthi, mtlo, acc;
  logic [31:0] op_a, op_b, wdata;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic [63:0] mul_y, p1, p2;
  logic        busy, done, stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .rd_req(rd_req), .mthi(mthi),
    .mtlo(mtlo), .wdata(wdata), .mul_a(mul_a), .mul_b(mul_b),
    .mul_y(mul_y), .hi(hi), .lo(lo), .busy(busy), .done(done),
`ifdef MUL_CTRL_MADD_EN
    .acc(acc),
`endif
    .stall(stall)
  );

  always @(posedge clk) begin
    p1 <= {32'd0, mul_a} * {32'd0, mul_b};
    p2 <= p1;
  end
  assign mul_y = p2;

  function automatic logic [63:0] prod_of(logic s, logic [31:0] a,
                                          logic [31:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_prod = 0;
  logic        m_acc = 0, m_done = 0, m_ready = 0;
  logic        acc_in;

`ifdef MUL_CTRL_MADD_EN
  assign acc_in = acc;
`else
  assign acc_in = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst) begin
      m_left  <= 0;
      m_hi    <= 0;
      m_lo    <= 0;
      m_done  <= 0;
      m_ready <= 1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= 0;
      if (m_left == 1) begin
        {m_hi, m_lo} <= (m_acc ? {m_hi, m_lo} : 64'd0) + m_prod;
        m_done <= 1;
      end
    end else begin
      m_done <= 0;
      if (mthi) m_hi <= wdata;
      if (mtlo) m_lo <= wdata;
      if (start) begin
        m_left <= MUL_LAT;
        m_prod <= prod_of(is_signed, op_a, op_b);
        m_acc  <= acc_in;
      end
    end
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready && rst) begin
      chk("m_hi", 64'(hi), 64'(m_hi));
      chk("m_lo", 64'(lo), 64'(m_lo));
      chk("m_busy", 64'(busy), 64'(m_left > 0));
      chk("m_done", 64'(done), 64'(m_done));
      chk("m_stall", 64'(stall),
          64'((m_left > 0) && (start || rd_req || mthi || mtlo)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(logic s, logic [31:0] a, logic [31:0] b, logic ac);
    start = 1; is_signed = s; op_a = a; op_b = b; acc = ac;
    tick();
    start = 0;
  endtask

  initial begin
    rst = 0; start = 0; is_signed = 0; rd_req = 0;
    mthi = 0; mtlo = 0; acc = 0; op_a = 0; op_b = 0; wdata = 0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1;
    tick();

    go(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    #1 chk("u_busy1", 64'(busy), 64'd1);
    tick(); chk("u_busy2", 64'(busy), 64'd1);
    tick(); chk("u_done", 64'(done), 64'd1);
    chk("u_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    tick(); chk("u_done_off", 64'(done), 64'd0);

    go(1, 32'hFFFF_FFFD, 32'd7, 0);
    tick(); tick();
    chk("s_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();

    start = 1; is_signed = 1; op_a = 32'h8000_0000; op_b = 32'h8000_0000;
    #1 chk("s_mag_a", 64'(mul_a), 64'h8000_0000);
    tick(); start = 0;
    tick(); tick();
    chk("s_min2", {hi, lo}, 64'h4000_0000_0000_0000);
    tick();

    go(0, 32'd5, 32'd6, 0);
    start = 1; op_a = 32'd2; op_b = 32'd3; rd_req = 1;
    #1 chk("st_c1", 64'(stall), 64'd1);
    tick(); chk("st_c2", 64'(stall), 64'd1);
    tick(); rd_req = 0;
    #1 chk("st_c3", 64'(stall), 64'd0);
    chk("st_lo30", 64'(lo), 64'd30);
    tick(); start = 0;
    chk("st_busy4", 64'(busy), 64'd1);
    tick(); tick();
    chk("st_done6", 64'(done), 64'd1);
    chk("st_lo6", 64'(lo), 64'd6);
    tick();

    mthi = 1; wdata = 32'h1234;
    tick(); mthi = 0;
    chk("mthi_idle", 64'(hi), 64'h1234);

    go(0, 32'd1, 32'd1, 0);
    mtlo = 1; wdata = 32'hDEAD;
    #1 chk("mtlo_stall", 64'(stall), 64'd1);
    tick(); chk("mtlo_hold", 64'(lo), 64'd6);
    tick(); chk("mtlo_done", 64'(lo), 64'd1);
    tick(); mtlo = 0;
    chk("mtlo_after", 64'(lo), 64'hDEAD);

    go(0, 32'd7, 32'd7, 0);
    tick(); rst = 0;
    tick(); rst = 1;
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_done", 64'(done), 64'd0);
    chk("rr_hilo", {hi, lo}, 64'd0);
    tick(); tick(); tick();
    chk("rr_nowb", {hi, lo}, 64'd0);

`ifdef MUL_CTRL_MADD_EN
    mtlo = 1; mthi = 1; wdata = 32'd0;
    tick(); mthi = 0; wdata = 32'd5;
    tick(); mtlo = 0;
    go(0, 32'd2, 32'd3, 1);
    tick(); tick();
    chk("madd_11", {hi, lo}, 64'd11);
    mtlo = 1; wdata = 32'hFFFF_FFFF;
    tick(); mtlo = 0;
    go(0, 32'd1, 32'd1, 1);
    tick(); tick();
    chk("madd_carry", {hi, lo}, 64'h1_0000_0000);
    tick();
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller for the 2-stage pipelined 32x32 unsigned multiplier.
- Accepts one multiply at a time from the execute stage and drives the multiplier operands.
- Handles signed operands by sign-magnitude conversion.
- Tracks pipeline latency, writes the 64-bit product into architectural HI/LO registers, and raises stall for HI/LO accesses while an operation is in flight.

Parameters:
- MUL_LAT, 2: clock edges from operand presentation to a valid mul_y (multiplier pipeline depth).
- CNT_W, 2: width of the latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a multiply with op_a/op_b this cycle.
- is_signed  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start.
- op_a  in  32  multiplicand.
- op_b  in  32  multiplier.
- rd_req  in  1  execute stage is reading HI or LO this cycle (MFHI/MFLO).
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  32  write data for mthi/mtlo.
- mul_a  out  32  operand A to the multiplier.
- mul_b  out  32  operand B to the multiplier.
- mul_y  in  64  unsigned product from the multiplier.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO first show the new product.
- stall  out  1  pipeline stall request.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, neg flag=0.
  - Reset mid-operation abandons the op; the product is never written.
- Operand drive (combinational, every cycle):
  - mul_a = (is_signed & op_a[31]) ? -op_a : op_a; mul_b likewise from op_b.
  - The two's-complement negation of 0x80000000 yields 0x80000000, which is correct as an unsigned magnitude.
  - Outside an accepted start the multiplier captures don't-care values; the controller ignores them.
- FSM states: IDLE, RUN, WB.
  - IDLE: start=1 → accept. Latch neg = is_signed & (op_a[31]^op_b[31]), counter=1, go to RUN. busy=0 in IDLE.
  - RUN: busy=1. Counter increments each edge. When counter==MUL_LAT, mul_y is valid this cycle: capture {hi,lo} = neg ? -mul_y : mul_y (64-bit negate), go to WB.
  - WB: busy=0, done=1 for exactly one cycle, hi/lo show the new product. start is accepted in WB exactly as in IDLE. Without start, go to IDLE.
- Timing (default MUL_LAT=2):
  - start in cycle 0; busy in cycles 1–2; capture at end of cycle 2; done and new hi/lo in cycle 3.
  - Issue-to-issue throughput: one op per 3 cycles.
- stall = busy & (start | rd_req | mthi | mtlo).
  - While stalled, start is not accepted and mthi/mtlo writes are not performed.
  - The requester holds the request until stall drops.
- mthi/mtlo when not busy: write at the edge; both may assert together.
  - In the same cycle as an accepted start, the writes take effect, then are overwritten by the product at capture.
- 64-bit results are exact; no overflow is possible.
  - Signed range: −2^62+2^31 .. 2^62.
  - Unsigned max: 0xFFFFFFFE_00000001.

Optional Feature:
- Macro MUL_CTRL_MADD_EN.
- Defined:
  - Adds input port acc (1 bit), sampled with start.
  - When acc=1, capture computes {hi,lo} = {hi,lo} + signed-adjusted product (MADD/MADDU), modulo 2^64.
  - The {hi,lo} value used is the one present at capture.
- Undefined: no acc port; capture always overwrites {hi,lo}.

Test Plan:
- Unsigned op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, start in cycle 0 → busy cycles 1–2; done=1 in cycle 3 with hi=0xFFFFFFFE, lo=0x00000001.
- Signed −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Signed 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- rd_req=1 in cycle 1 after start → stall=1 in cycles 1–2, stall=0 in cycle 3; start held in cycle 1 is accepted only in cycle 3, with the next done in cycle 6.
- mthi wdata=0x1234 while idle → hi=0x1234 next cycle. mtlo during busy → stall=1 and lo unchanged until done.
- rst=0 in cycle 2 of an op → cycle 3: busy=0, done=0, hi=lo=0; no later writeback.
- With MUL_CTRL_MADD_EN: hi/lo=0/5, then start acc=1 unsigned 2×3 → lo=11, hi=0. Starting from hi=0, lo=0xFFFFFFFF with acc=1, 1×1 → hi=1, lo=0.
